// File: rtl/sequence_gen.sv
// Simon Says colour sequence store: a free-running Galois LFSR supplies colours,
// one colour is appended per accepted add_step, with a rule that forbids three-in-a-row.
module sequence_gen #(
  parameter int unsigned DEPTH = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic                           add_step,
  output logic [DEPTH-1:0][2:0]          segment,
  output logic [$clog2(DEPTH+1)-1:0]     length,
  output logic                           full,
  output logic                           added
);

  localparam int unsigned LenW     = $clog2(DEPTH + 1);
  localparam logic [15:0] SeedInit = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0]            lfsr_q, lfsr_d;
  logic [DEPTH-1:0][2:0]  seg_q, seg_d;
  logic [LenW-1:0]        len_q, len_d;
  logic                   full_q, full_d;
  logic                   added_q, added_d;

  logic [1:0] cand, last_c, prev_c, colour;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Pick out the two most recent colours without a variable-width index.
    last_c = 2'b00;
    prev_c = 2'b00;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (LenW'(i + 1) == len_q) last_c = seg_q[i][1:0];
      if (LenW'(i + 2) == len_q) prev_c = seg_q[i][1:0];
    end

    cand   = lfsr_q[1:0];
    colour = ((len_q >= LenW'(2)) && (cand == last_c) && (cand == prev_c)) ? cand + 2'd1 : cand;

    seg_d   = seg_q;
    len_d   = len_q;
    added_d = 1'b0;

    if (new_game) begin
      seg_d = {DEPTH{3'b100}};
      len_d = '0;
    end else if (add_step && !full_q) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (LenW'(i) == len_q) seg_d[i] = {1'b0, colour};
      end
      len_d   = len_q + LenW'(1);
      added_d = 1'b1;
    end

    full_d = (len_d == LenW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= SeedInit;
      seg_q   <= {DEPTH{3'b100}};
      len_q   <= '0;
      full_q  <= 1'b0;
      added_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      full_q  <= full_d;
      added_q <= added_d;
    end
  end

  assign segment = seg_q;
  assign length  = len_q;
  assign full    = full_q;
  assign added   = added_q;

endmodule
